// File: rtl/bus_decoder_pkg.sv
// Shared types and widths for the bus_decoder address decoder and its region matcher.
package bus_decoder_pkg;

  localparam int IDX_W  = 5;
  localparam int WAIT_W = 4;
  localparam int MISS_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    MISS
  } state_t;

endpackage

// File: rtl/bus_decoder_region_match.sv
// Combinational priority matcher: lowest enabled matching region wins, giving
// a one-hot select and its index.
module region_match
  import bus_decoder_pkg::*;
#(
  parameter int                              ADDR_W       = 24,
  parameter int                              NUM_REGIONS  = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE  = '0,
  parameter logic [NUM_REGIONS*5-1:0]        REGION_WIDTH = '0
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NUM_REGIONS-1:0] region_en,
  output logic                   match,
  output logic [NUM_REGIONS-1:0] onehot,
  output logic [IDX_W-1:0]       idx
);

  // Walk from the top index down so the lowest matching region is the last writer.
  always_comb begin
    match  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (region_en[i] &&
          ((addr >> REGION_WIDTH[i*5 +: 5]) ==
           (REGION_BASE[i*ADDR_W +: ADDR_W] >> REGION_WIDTH[i*5 +: 5]))) begin
        match     = 1'b1;
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_decoder.sv
// CPU bus address decoder with per-region wait states and DTACK generation.
// Optional unmapped-access bus error timeout enabled by macro BUS_DECODER_BERR_EN.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int                                 ADDR_W       = 24,
  parameter int                                 NUM_REGIONS  = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]      REGION_BASE  = '0,
  parameter logic [NUM_REGIONS*5-1:0]           REGION_WIDTH = '0,
  parameter logic [NUM_REGIONS*WAIT_W-1:0]      REGION_WAIT  = '0,
  parameter int                                 BERR_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      cpu_a,
  input  logic                   cpu_as_n,
  input  logic [NUM_REGIONS-1:0] region_en,
  output logic [NUM_REGIONS-1:0] cs,
  output logic [IDX_W-1:0]       cs_idx,
  output logic                   hit,
  output logic                   dtack_n,
  output logic                   berr_n
);

  if (NUM_REGIONS < 1 || NUM_REGIONS > 32 || BERR_TIMEOUT < 1 || BERR_TIMEOUT > 1023) begin : g_param_check
    $error("bus_decoder: NUM_REGIONS or BERR_TIMEOUT out of range");
  end

  state_t                   state, state_next;
  logic                     armed;
  logic [NUM_REGIONS-1:0]   cs_lat;
  logic [IDX_W-1:0]         idx_lat;
  logic [WAIT_W-1:0]        wait_cnt;
  logic                     dec_match;
  logic [NUM_REGIONS-1:0]   dec_onehot;
  logic [IDX_W-1:0]         dec_idx;
  logic [WAIT_W-1:0]        dec_wait;

  region_match #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_WIDTH(REGION_WIDTH)
  ) u_match (
    .addr     (cpu_a),
    .region_en(region_en),
    .match    (dec_match),
    .onehot   (dec_onehot),
    .idx      (dec_idx)
  );

  always_comb begin
    dec_wait = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (dec_idx == IDX_W'(i)) dec_wait = REGION_WAIT[i*WAIT_W +: WAIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (armed && !cpu_as_n) state_next = dec_match ? WAIT : MISS;
      WAIT: begin
        if (cpu_as_n)            state_next = IDLE;
        else if (wait_cnt == '0) state_next = ACK;
      end
      ACK:  if (cpu_as_n) state_next = IDLE;
      MISS: if (cpu_as_n) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A strobe is only accepted once AS has been seen high while idle, so a
  // held-low AS (after an access or a reset) never starts a second cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed    <= 1'b0;
      cs_lat   <= '0;
      idx_lat  <= '0;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (cpu_as_n) begin
        armed <= 1'b1;
      end else if (armed) begin
        armed    <= 1'b0;
        cs_lat   <= dec_onehot;
        idx_lat  <= dec_idx;
        wait_cnt <= dec_wait;
      end
    end else if (state == WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

`ifdef BUS_DECODER_BERR_EN
  logic [MISS_W-1:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (reset || state == IDLE)
      miss_cnt <= '0;
    else if (state == MISS && miss_cnt != MISS_W'(BERR_TIMEOUT))
      miss_cnt <= miss_cnt + 1'b1;
  end
`endif

  always_comb begin
    hit     = (state == WAIT) || (state == ACK);
    cs      = hit ? cs_lat : '0;
    cs_idx  = hit ? idx_lat : '0;
    dtack_n = (state != ACK);
`ifdef BUS_DECODER_BERR_EN
    berr_n  = !((state == MISS) && (miss_cnt == MISS_W'(BERR_TIMEOUT)));
`else
    berr_n  = 1'b1;
`endif
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed scenarios plus randomized
// accesses checked against a per-access timing model.
module tb_bus_decoder;

  localparam int AW  = 24;
  localparam int NR  = 8;
  localparam int TMO = 8;

  localparam logic [NR*AW-1:0] BASES = {24'h600000, 24'h500000, 24'h100000, 24'h400000,
                                        24'h200000, 24'h100000, 24'h080000, 24'h000000};
  localparam logic [NR*5-1:0]  WIDTHS = {5'd20, 5'd0, 5'd8, 5'd16, 5'd8, 5'd4, 5'd14, 5'd12};
  localparam logic [NR*4-1:0]  WAITS  = {4'd4, 4'd15, 4'd3, 4'd10, 4'd5, 4'd1, 4'd0, 4'd2};

  int m_base  [NR] = '{'h000000, 'h080000, 'h100000, 'h200000, 'h400000, 'h100000, 'h500000, 'h600000};
  int m_width [NR] = '{12, 14, 4, 8, 16, 8, 0, 20};
  int m_wait  [NR] = '{2, 0, 1, 5, 10, 3, 15, 4};

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_a;
  logic          cpu_as_n;
  logic [NR-1:0] region_en;
  logic [NR-1:0] cs;
  logic [4:0]    cs_idx;
  logic          hit;
  logic          dtack_n;
  logic          berr_n;

  int total = 0;
  int bad   = 0;

  bus_decoder #(
    .ADDR_W      (AW),
    .NUM_REGIONS (NR),
    .REGION_BASE (BASES),
    .REGION_WIDTH(WIDTHS),
    .REGION_WAIT (WAITS),
    .BERR_TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_a    (cpu_a),
    .cpu_as_n (cpu_as_n),
    .region_en(region_en),
    .cs       (cs),
    .cs_idx   (cs_idx),
    .hit      (hit),
    .dtack_n  (dtack_n),
    .berr_n   (berr_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: lowest enabled region whose address bits above its width agree.
  function automatic int modelIdx(input int a, input logic [NR-1:0] en);
    for (int i = 0; i < NR; i++) begin
      if (en[i] && ((a >> m_width[i]) == (m_base[i] >> m_width[i]))) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleGap(input int n);
    cpu_as_n = 1'b1;
    repeat (n) tick();
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".hit"}, int'(hit), 0);
    checkOutput({tag, ".cs"}, int'(cs), 0);
    checkOutput({tag, ".dtack_n"}, int'(dtack_n), 1);
    checkOutput({tag, ".berr_n"}, int'(berr_n), 1);
  endtask

  // Expected outputs c cycles after the strobe was first sampled low.
  task automatic checkCycle(input int idx, input int c);
    int exp_berr;
    if (idx >= 0) begin
      checkOutput("hit", int'(hit), 1);
      checkOutput("cs", int'(cs), 1 << idx);
      checkOutput("cs_idx", int'(cs_idx), idx);
      checkOutput("dtack_n", int'(dtack_n), (c >= m_wait[idx] + 2) ? 0 : 1);
      checkOutput("berr_n", int'(berr_n), 1);
    end else begin
      exp_berr = 1;
`ifdef BUS_DECODER_BERR_EN
      if (c >= TMO + 1) exp_berr = 0;
`endif
      checkOutput("miss.hit", int'(hit), 0);
      checkOutput("miss.cs", int'(cs), 0);
      checkOutput("miss.dtack_n", int'(dtack_n), 1);
      checkOutput("miss.berr_n", int'(berr_n), exp_berr);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [NR-1:0] en,
                               input int hold, input bit scramble);
    int idx;
    idx       = modelIdx(int'(addr), en);
    cpu_a     = addr;
    region_en = en;
    cpu_as_n  = 1'b0;
    for (int c = 1; c <= hold; c++) begin
      tick();
      if (scramble) begin
        cpu_a     = AW'($urandom);
        region_en = NR'($urandom);
      end
      checkCycle(idx, c);
    end
    cpu_as_n = 1'b1;
    tick();
    checkIdle("release");
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] addr;
    logic [NR-1:0] en;
    int r;

    reset     = 1'b1;
    cpu_as_n  = 1'b1;
    cpu_a     = '0;
    region_en = '1;
    repeat (2) tick();
    checkIdle("reset");
    checkOutput("reset.cs_idx", int'(cs_idx), 0);
    reset = 1'b0;
    idleGap(2);

    applyStimulus(24'h081234, '1, 4, 1'b0);
    idleGap(2);
    applyStimulus(24'h200010, '1, 9, 1'b0);
    idleGap(2);
    applyStimulus(24'h100002, '1, 5, 1'b0);
    idleGap(2);
    applyStimulus(24'h100002, 8'b1111_1011, 6, 1'b0);
    idleGap(2);
    applyStimulus(24'h3F0000, '1, 12, 1'b0);
    idleGap(2);
    applyStimulus(24'h400123, '1, 2, 1'b1);
    idleGap(2);
    applyStimulus(24'h500000, '1, 3, 1'b0);

    // AS seen high only on the release edge: a new strobe must not be taken yet.
    cpu_a    = 24'h081234;
    cpu_as_n = 1'b0;
    repeat (3) begin
      tick();
      checkIdle("rearm");
    end
    idleGap(1);
    applyStimulus(24'h081234, '1, 3, 1'b0);

    // Reset in the middle of an acknowledged access.
    idleGap(2);
    cpu_a     = 24'h081234;
    region_en = '1;
    cpu_as_n  = 1'b0;
    repeat (2) tick();
    checkOutput("pre_reset.dtack_n", int'(dtack_n), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkIdle("mid_reset");
    checkOutput("mid_reset.cs_idx", int'(cs_idx), 0);
    repeat (3) begin
      tick();
      checkIdle("as_held_after_reset");
    end
    idleGap(1);
    applyStimulus(24'h200055, '1, 8, 1'b0);

    repeat (40) begin
      idleGap($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        addr = AW'($urandom);
      end else begin
        r    = $urandom_range(0, NR - 1);
        addr = AW'(m_base[r] + int'($urandom & ((32'd1 << m_width[r]) - 1)));
      end
      en = '1;
      if ($urandom_range(0, 2) == 0) en[$urandom_range(0, NR - 1)] = 1'b0;
      applyStimulus(addr, en, $urandom_range(1, 19), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
